if_fetch: RTL and testbench

- Instruction-fetch stage. Sits directly upstream of the IF/ID pipeline register and feeds it `if_pc` / `if_inst`.
- Owns the PC and runs a req/ack handshake with instruction memory, which may insert wait states.
- Holds one fetched instruction in a single-entry output buffer and raises a stall request while no instruction is ready.
- Implements MIPS branch redirect with one delay slot.

---
 rtl/if_fetch.sv | 148 ++++++++++++++
 tb/tb_if_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, holds one
// fetched instruction for IF/ID and applies MIPS branch redirects with one delay slot.
module if_fetch #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              stallreq_if_o
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] RESET_ADDR = {RESET_PC[ADDR_W-1:2], 2'b00};

  typedef enum logic {S_IDLE, S_FETCH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0] redirect_addr_q, redirect_addr_d;
  logic              kill_q, kill_d;

  logic              fetching, consume, launch, req, ack, taken;
  logic              discard, ack_good, case_a;
  logic [ADDR_W-1:0] cur_addr, target;

  logic unused_inputs;
  assign unused_inputs = ^{stall[5:3], stall[0], branch_target_address_i[1:0]};

  // Handshake and branch decode for the current cycle
  always_comb begin
    fetching = (state_q == S_FETCH);
    consume  = buf_valid_q && !stall[1];
    launch   = fetching && !pend_q && (!buf_valid_q || consume);
    req      = pend_q || launch;
    cur_addr = pend_q ? req_addr_q : fetch_pc_q;
    ack      = req && imem_ack_i;
    taken    = fetching && branch_flag_i && !stall[2];
    target   = {branch_target_address_i[ADDR_W-1:2], 2'b00};
    // Delay slot is buffered, so a same-cycle ack belongs to the wrong path
    discard  = taken && buf_valid_q && ack && !kill_q;
    ack_good = ack && !kill_q && !discard;
    case_a   = taken && (buf_valid_q || ack_good);
  end

  // Next-state logic
  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    pend_d           = pend_q;
    req_addr_d       = req_addr_q;
    buf_valid_d      = buf_valid_q;
    if_pc_d          = if_pc_q;
    if_inst_d        = if_inst_q;
    redirect_valid_d = redirect_valid_q;
    redirect_addr_d  = redirect_addr_q;
    kill_d           = kill_q;

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    if (launch && !ack) begin
      pend_d     = 1'b1;
      req_addr_d = fetch_pc_q;
    end
    if (ack) begin
      pend_d = 1'b0;
    end
    if (consume) begin
      buf_valid_d = 1'b0;
    end
    if (ack && kill_q) begin
      kill_d = 1'b0;
    end

    if (ack_good) begin
      if_inst_d        = imem_rdata_i;
      if_pc_d          = cur_addr;
      buf_valid_d      = 1'b1;
      fetch_pc_d       = redirect_valid_q ? redirect_addr_q : cur_addr + PC_STEP;
      redirect_valid_d = 1'b0;
    end

    if (taken) begin
      if (case_a) begin
        fetch_pc_d = target;
        // Sequential fetch past the delay slot still outstanding: drop its data
        if (buf_valid_q && req && !ack) begin
          kill_d = 1'b1;
        end
      end else begin
        redirect_valid_d = 1'b1;
        redirect_addr_d  = target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      fetch_pc_q       <= RESET_ADDR;
      pend_q           <= 1'b0;
      req_addr_q       <= '0;
      buf_valid_q      <= 1'b0;
      if_pc_q          <= '0;
      if_inst_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      kill_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      pend_q           <= pend_d;
      req_addr_q       <= req_addr_d;
      buf_valid_q      <= buf_valid_d;
      if_pc_q          <= if_pc_d;
      if_inst_q        <= if_inst_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      kill_q           <= kill_d;
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = req ? cur_addr : '0;
  assign if_pc         = if_pc_q;
  assign if_inst       = if_inst_q;
  assign stallreq_if_o = !buf_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: wait-state memory model, program-order PC model checked on every
// IF/ID capture, handshake invariants, and directed cycle-exact expectations.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if_o;

  int tests = 0;
  int fails = 0;

  if_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .imem_req_o              (imem_req_o),
    .imem_addr_o             (imem_addr_o),
    .imem_ack_i              (imem_ack_i),
    .imem_rdata_i            (imem_rdata_i),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
    .stallreq_if_o           (stallreq_if_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: acks after a per-address number of wait cycles; ack_force models a stray ack
  int unsigned base_wait, slow_wait, wcnt, need;
  logic [31:0] slow_addr;
  logic        ack_force;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (imem_req_o && !imem_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always_comb begin
    need         = (imem_addr_o == slow_addr) ? slow_wait : base_wait;
    imem_ack_i   = ack_force || (imem_req_o && (wcnt >= need));
    imem_rdata_i = ack_force ? 32'hBAD0_BAD0 : inst_of(imem_addr_o);
  end

  // Program-order model: each IF/ID capture must be the next instruction in MIPS order
  logic [31:0] model_pc, armed_tgt, prev_addr;
  logic        armed, have_prev, cons, taken;

  always @(negedge clk) begin
    if (!rst) begin
      model_pc  = 32'h0;
      armed     = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (imem_req_o) chk("addr_align", 32'(imem_addr_o[1:0]), 32'h0);
      if (have_prev) begin
        chk("req_hold", 32'(imem_req_o), 32'h1);
        chk("addr_hold", imem_addr_o, prev_addr);
      end
      have_prev = imem_req_o && !imem_ack_i;
      prev_addr = imem_addr_o;
      cons  = !stallreq_if_o && !stall[1];
      taken = branch_flag_i && !stall[2];
      if (cons) begin
        chk("seq_pc", if_pc, model_pc);
        chk("seq_inst", if_inst, inst_of(model_pc));
        if (taken) model_pc = branch_target_address_i;
        else if (armed) begin
          model_pc = armed_tgt;
          armed    = 1'b0;
        end else model_pc = model_pc + 32'd4;
      end else if (taken) begin
        armed     = 1'b1;
        armed_tgt = branch_target_address_i;
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Ends just after release: the following cycle is cycle 0 (IDLE)
  task automatic do_reset(input int unsigned bw, input logic [31:0] sa, input int unsigned sw);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = '0;
    branch_flag_i = 1'b0;
    branch_target_address_i = '0;
    ack_force = 1'b0;
    base_wait = bw;
    slow_addr = sa;
    slow_wait = sw;
    adv(2);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    stall = '0;
    branch_flag_i = 1'b0;
    branch_target_address_i = '0;
    ack_force = 1'b0;
    base_wait = 0;
    slow_wait = 0;
    slow_addr = 32'hFFFF_FFF0;
    #1;
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_stallreq", 32'(stallreq_if_o), 32'h1);

    // Zero-wait memory: one instruction per cycle
    do_reset(0, 32'hFFFF_FFF0, 0);
    neg(); chk("t1_idle_req", 32'(imem_req_o), 32'h0);
    adv(1); neg();
    chk("t1_c1_req", 32'(imem_req_o), 32'h1);
    chk("t1_c1_addr", imem_addr_o, 32'h0);
    chk("t1_c1_stallreq", 32'(stallreq_if_o), 32'h1);
    adv(1); neg();
    chk("t1_c2_pc", if_pc, 32'h0);
    chk("t1_c2_stallreq", 32'(stallreq_if_o), 32'h0);
    chk("t1_c2_addr", imem_addr_o, 32'h4);
    adv(1); neg(); chk("t1_c3_pc", if_pc, 32'h4);
    adv(1); neg(); chk("t1_c4_pc", if_pc, 32'h8);
    adv(1); neg(); chk("t1_c5_pc", if_pc, 32'hC);

    // Three wait cycles: request held four cycles, one instruction every four cycles
    do_reset(3, 32'hFFFF_FFF0, 0);
    adv(1); neg();
    chk("t2_c1_req", 32'(imem_req_o), 32'h1);
    chk("t2_c1_ack", 32'(imem_ack_i), 32'h0);
    adv(3); neg();
    chk("t2_c4_addr", imem_addr_o, 32'h0);
    chk("t2_c4_ack", 32'(imem_ack_i), 32'h1);
    chk("t2_c4_stallreq", 32'(stallreq_if_o), 32'h1);
    adv(1); neg();
    chk("t2_c5_pc", if_pc, 32'h0);
    chk("t2_c5_stallreq", 32'(stallreq_if_o), 32'h0);
    chk("t2_c5_addr", imem_addr_o, 32'h4);
    adv(1); neg();
    chk("t2_c6_stallreq", 32'(stallreq_if_o), 32'h1);
    chk("t2_c6_pc", if_pc, 32'h0);
    adv(3); neg();
    chk("t2_c9_pc", if_pc, 32'h4);
    chk("t2_c9_addr", imem_addr_o, 32'h8);

    // IF/ID stalled with 0x8 buffered: no request until release
    do_reset(0, 32'hFFFF_FFF0, 0);
    adv(4);
    stall = 6'b000010;
    neg();
    chk("t3_c4_pc", if_pc, 32'h8);
    chk("t3_c4_req", 32'(imem_req_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      adv(1); neg();
      chk("t3_hold_req", 32'(imem_req_o), 32'h0);
      chk("t3_hold_pc", if_pc, 32'h8);
    end
    adv(1);
    stall = '0;
    neg();
    chk("t3_rel_req", 32'(imem_req_o), 32'h1);
    chk("t3_rel_addr", imem_addr_o, 32'hC);
    adv(1); neg(); chk("t3_after_pc", if_pc, 32'hC);

    // Branch with delay slot buffered; sequential 0x10 fetch in flight is killed
    do_reset(0, 32'h0000_0010, 3);
    adv(5);
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h100;
    neg();
    chk("t4_c5_pc", if_pc, 32'hC);
    chk("t4_c5_addr", imem_addr_o, 32'h10);
    adv(1);
    branch_flag_i = 1'b0;
    neg();
    chk("t4_c6_stallreq", 32'(stallreq_if_o), 32'h1);
    adv(2); neg();
    chk("t4_c8_ack", 32'(imem_ack_i), 32'h1);
    chk("t4_c8_addr", imem_addr_o, 32'h10);
    adv(1); neg();
    chk("t4_kill_pc", if_pc, 32'hC);
    chk("t4_kill_stallreq", 32'(stallreq_if_o), 32'h1);
    chk("t4_tgt_addr", imem_addr_o, 32'h100);
    adv(1); neg();
    chk("t4_tgt_pc", if_pc, 32'h100);
    chk("t4_tgt_inst", if_inst, inst_of(32'h100));
    adv(1); neg(); chk("t4_tgt4_pc", if_pc, 32'h104);

    // Branch while delay slot 0x10 is still in flight
    do_reset(0, 32'h0000_0010, 3);
    adv(6);
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h200;
    neg();
    chk("t5_c6_stallreq", 32'(stallreq_if_o), 32'h1);
    chk("t5_c6_addr", imem_addr_o, 32'h10);
    adv(1);
    branch_flag_i = 1'b0;
    adv(1); neg();
    chk("t5_c8_ack", 32'(imem_ack_i), 32'h1);
    adv(1); neg();
    chk("t5_ds_pc", if_pc, 32'h10);
    chk("t5_tgt_addr", imem_addr_o, 32'h200);
    adv(1); neg(); chk("t5_tgt_pc", if_pc, 32'h200);
    adv(1); neg(); chk("t5_tgt4_pc", if_pc, 32'h204);

    // Reset mid-request at 0x14, stray ack in IDLE
    do_reset(0, 32'h0000_0014, 3);
    adv(7); neg();
    chk("t6_c7_addr", imem_addr_o, 32'h14);
    chk("t6_c7_req", 32'(imem_req_o), 32'h1);
    adv(1);
    rst = 1'b0;
    #1;
    chk("t6_rst_req", 32'(imem_req_o), 32'h0);
    chk("t6_rst_addr", imem_addr_o, 32'h0);
    chk("t6_rst_pc", if_pc, 32'h0);
    chk("t6_rst_inst", if_inst, 32'h0);
    chk("t6_rst_stallreq", 32'(stallreq_if_o), 32'h1);
    ack_force = 1'b1;
    adv(2);
    rst = 1'b1;
    neg();
    chk("t6_idle_req", 32'(imem_req_o), 32'h0);
    adv(1);
    ack_force = 1'b0;
    neg();
    chk("t6_c1_inst", if_inst, 32'h0);
    chk("t6_c1_stallreq", 32'(stallreq_if_o), 32'h1);
    chk("t6_c1_addr", imem_addr_o, 32'h0);
    chk("t6_c1_req", 32'(imem_req_o), 32'h1);
    adv(1); neg();
    chk("t6_c2_pc", if_pc, 32'h0);
    chk("t6_c2_inst", if_inst, inst_of(32'h0));
    adv(2); neg();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
